// File: rtl/fini_mul_correct_pipe.sv
// ---------------------------------------------------------------------------
// fini_mul_correct_pipe
//
// Two-stage pipelined AND of two repetition-coded operands with per-bit
// replica voting. Each logical bit is carried as N = 2K+1 replicas. Stage 1
// registers the raw replica-wise AND. Stage 2 votes each logical bit over its
// replicas and re-emits the result in the same repetition-coded layout.
// In correct mode (MODE=0) every replica of a result bit takes the majority
// value. In detect mode (MODE=1) any replica disagreement zeroes the whole
// result. A saturating counter tallies results that carried a disagreement.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operand pair valid
//   in_ready    block can accept an operand pair this cycle
//   port_a/b    operands, replica r of bit i at index r*WIDTH+i
//   out_valid   result valid
//   out_ready   consumer accepts the result
//   port_c      voted result, same layout, all replicas of a bit identical
//   fault_flag  result had at least one replica disagreement (with out_valid)
//   fault_cnt   saturating count of flagged results handed downstream
//   clr_cnt     synchronous clear of fault_cnt, wins over an increment
// ---------------------------------------------------------------------------
module fini_mul_correct_pipe #(
   parameter int K     = 1,
   parameter int WIDTH = 4,
   parameter int MODE  = 0,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH*(2*K+1)-1:0]   port_a,
   input  logic [WIDTH*(2*K+1)-1:0]   port_b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH*(2*K+1)-1:0]   port_c,
   output logic                       fault_flag,
   output logic [CNT_W-1:0]           fault_cnt,
   input  logic                       clr_cnt
);

   localparam int N  = 2*K+1;
   localparam int DW = WIDTH*N;
   // Wide enough to hold a ones-count of 0..N.
   localparam int CW = $clog2(N+1);

   // Stage 1: replica-wise AND, no voting yet.
   logic              s1_valid_q, s1_valid_d;
   logic [DW-1:0]     s1_p_q, s1_p_d;

   // Stage 2: voted result, presented on the output ports.
   logic              s2_valid_q, s2_valid_d;
   logic [DW-1:0]     port_c_q, port_c_d;
   logic              fault_flag_q, fault_flag_d;
   logic [CNT_W-1:0]  fault_cnt_q, fault_cnt_d;

   logic              s2_can_load;
   logic              out_xfer;

   // Voter signals.
   logic [CW-1:0]     ones [WIDTH];
   logic [WIDTH-1:0]  maj;
   logic [WIDTH-1:0]  dis;
   logic [DW-1:0]     vote_c;
   logic              vote_flag;

   // -------------------------------------------------------------------------
   // Voter over the stage-1 products. maj needs at least K+1 ones out of N;
   // a bit disagrees when its replicas are neither all 0 nor all 1. With K=0
   // there is a single replica, so dis can never be set.
   // -------------------------------------------------------------------------
   always_comb begin
      maj       = '0;
      dis       = '0;
      vote_c    = '0;
      vote_flag = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         ones[i] = '0;
         for (int r = 0; r < N; r++) begin
            ones[i] = ones[i] + CW'(s1_p_q[r*WIDTH+i]);
         end
         maj[i] = (ones[i] >= CW'(K+1));
         dis[i] = (ones[i] != '0) && (ones[i] != CW'(N));
      end
      vote_flag = |dis;
      for (int r = 0; r < N; r++) begin
         for (int i = 0; i < WIDTH; i++) begin
            vote_c[r*WIDTH+i] = maj[i];
         end
      end
      if (MODE == 1 && vote_flag) begin
         vote_c = '0;
      end
   end

   // -------------------------------------------------------------------------
   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends on ready. Stage 2 loads whenever it is
   // empty or its result is being taken, and stage 1 may accept whenever it is
   // empty or is about to hand its content to stage 2. This gives one result
   // per cycle, and under backpressure both stages hold their data, so
   // in_ready falls only once both are full.
   // -------------------------------------------------------------------------
   always_comb begin
      s2_can_load = !s2_valid_q || out_ready;
      in_ready    = !s1_valid_q || s2_can_load;
      out_xfer    = s2_valid_q && out_ready;

      s1_valid_d   = s1_valid_q;
      s1_p_d       = s1_p_q;
      s2_valid_d   = s2_valid_q;
      port_c_d     = port_c_q;
      fault_flag_d = fault_flag_q;
      fault_cnt_d  = fault_cnt_q;

      if (in_ready) begin
         // Stage 1 either takes a new pair or drains into stage 2.
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_p_d = port_a & port_b;
         end
      end

      if (s2_can_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            port_c_d     = vote_c;
            fault_flag_d = vote_flag;
         end
      end

      if (clr_cnt) begin
         fault_cnt_d = '0;
      end else if (out_xfer && fault_flag_q && (fault_cnt_q != '1)) begin
         fault_cnt_d = fault_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_p_q       <= '0;
         s2_valid_q   <= 1'b0;
         port_c_q     <= '0;
         fault_flag_q <= 1'b0;
         fault_cnt_q  <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_p_q       <= s1_p_d;
         s2_valid_q   <= s2_valid_d;
         port_c_q     <= port_c_d;
         fault_flag_q <= fault_flag_d;
         fault_cnt_q  <= fault_cnt_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign port_c     = port_c_q;
   assign fault_flag = fault_flag_q;
   assign fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_fini_mul_correct_pipe.sv
// ---------------------------------------------------------------------------
// Bench for fini_mul_correct_pipe. Four instances share one clock:
//   d0: K=1 WIDTH=4 MODE=0 CNT_W=8
//   d1: K=1 WIDTH=4 MODE=1 CNT_W=8   (same inputs as d0)
//   d3: K=1 WIDTH=4 MODE=0 CNT_W=2   (same inputs as d0)
//   d2: K=2 WIDTH=4 MODE=0 CNT_W=8   (own inputs, consumer always ready)
// A reference model keeps accepted operand pairs in a queue, computes the
// voted result per logical bit by counting ones, and derives handshake
// expectations from queue occupancy.
// ---------------------------------------------------------------------------
module tb_fini_mul_correct_pipe;

   logic        clk = 1'b0;
   logic        rst_n;

   // Shared inputs for d0/d1/d3.
   logic        in_valid, out_ready, clr_cnt;
   logic [11:0] a, b;
   logic        in_ready0, in_ready1, in_ready3;
   logic        out_valid0, out_valid1, out_valid3;
   logic [11:0] port_c0, port_c1, port_c3;
   logic        flag0, flag1, flag3;
   logic [7:0]  cnt0, cnt1;
   logic [1:0]  cnt3;

   // d2 (N=5).
   logic        in_valid2;
   logic        out_ready2 = 1'b1;
   logic        clr2 = 1'b0;
   logic [19:0] a2, b2;
   logic        in_ready2, out_valid2, flag2;
   logic [19:0] port_c2;
   logic [7:0]  cnt2;

   int checks = 0;
   int fails  = 0;

   // Model state.
   logic [23:0] qa[$];
   int          qa_acc[$];
   logic [39:0] qb[$];
   int          qb_acc[$];
   int          edges = 0;
   int          m0 = 0;
   int          m3 = 0;

   fini_mul_correct_pipe #(.K(1), .WIDTH(4), .MODE(0), .CNT_W(8)) d0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .port_a(a), .port_b(b), .out_valid(out_valid0), .out_ready(out_ready),
      .port_c(port_c0), .fault_flag(flag0), .fault_cnt(cnt0), .clr_cnt(clr_cnt));

   fini_mul_correct_pipe #(.K(1), .WIDTH(4), .MODE(1), .CNT_W(8)) d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .port_a(a), .port_b(b), .out_valid(out_valid1), .out_ready(out_ready),
      .port_c(port_c1), .fault_flag(flag1), .fault_cnt(cnt1), .clr_cnt(clr_cnt));

   fini_mul_correct_pipe #(.K(1), .WIDTH(4), .MODE(0), .CNT_W(2)) d3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
      .port_a(a), .port_b(b), .out_valid(out_valid3), .out_ready(out_ready),
      .port_c(port_c3), .fault_flag(flag3), .fault_cnt(cnt3), .clr_cnt(clr_cnt));

   fini_mul_correct_pipe #(.K(2), .WIDTH(4), .MODE(0), .CNT_W(8)) d2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .port_a(a2), .port_b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
      .port_c(port_c2), .fault_flag(flag2), .fault_cnt(cnt2), .clr_cnt(clr2));

   // ---------------- clock ----------------
   initial forever #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Replicate a 4-bit value n times.
   function automatic logic [19:0] rep(input logic [3:0] v, input int n);
      logic [19:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r[i*4 +: 4] = v;
      return r;
   endfunction

   // Reference: {flag, result} for replicated AND with K-fault voting.
   function automatic logic [20:0] ref_mul(input logic [19:0] x, input logic [19:0] y,
                                           input int k, input int mode);
      logic [19:0] c;
      bit          any;
      int          n;
      int          ones;
      n   = 2*k+1;
      c   = '0;
      any = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ones = 0;
         for (int r = 0; r < n; r++) if (x[r*4+i] && y[r*4+i]) ones++;
         if (ones != 0 && ones != n) any = 1'b1;
         if (ones > k) for (int r = 0; r < n; r++) c[r*4+i] = 1'b1;
      end
      if (mode == 1 && any) c = '0;
      return {any, c};
   endfunction

   // A result is presented when both stages are occupied, or when the single
   // item in flight has already moved on from the accepting edge.
   function automatic bit ov_exp(input int sz, input int acc_edge);
      return (sz >= 2) || (sz == 1 && edges > acc_edge);
   endfunction

   // One clock cycle: check the presented state, update the model with the
   // transfers about to happen, advance the clock, then check the counters.
   task automatic cyc(output bit acc);
      logic [23:0] pr;
      logic [39:0] pr2;
      logic [20:0] e0, e1, e2;
      bit          ir, ov, ov2, xf;
      #1;
      ir = (qa.size() < 2) || out_ready;
      ov = ov_exp(qa.size(), (qa.size() > 0) ? qa_acc[0] : 0);
      chk("in_ready0", in_ready0, ir);
      chk("in_ready3", in_ready3, ir);
      chk("out_valid0", out_valid0, ov);
      chk("out_valid1", out_valid1, ov);
      xf = ov && out_ready;
      e0 = '0;
      if (xf) begin
         pr = qa.pop_front();
         void'(qa_acc.pop_front());
         e0 = ref_mul({8'h0, pr[23:12]}, {8'h0, pr[11:0]}, 1, 0);
         e1 = ref_mul({8'h0, pr[23:12]}, {8'h0, pr[11:0]}, 1, 1);
         chk("c_mode0", port_c0, e0[11:0]);
         chk("flag_mode0", flag0, e0[20]);
         chk("c_mode1", port_c1, e1[11:0]);
         chk("flag_mode1", flag1, e1[20]);
         chk("c_cnt2bit", port_c3, e0[11:0]);
         chk("flag_cnt2bit", flag3, e0[20]);
      end
      if (clr_cnt) begin
         m0 = 0;
         m3 = 0;
      end else if (xf && e0[20]) begin
         if (m0 < 255) m0++;
         if (m3 < 3) m3++;
      end
      acc = in_valid && ir;
      if (acc) begin
         qa.push_back({a, b});
         qa_acc.push_back(edges + 1);
      end

      ov2 = ov_exp(qb.size(), (qb.size() > 0) ? qb_acc[0] : 0);
      chk("in_ready_k2", in_ready2, 1'b1);
      chk("out_valid_k2", out_valid2, ov2);
      if (ov2) begin
         pr2 = qb.pop_front();
         void'(qb_acc.pop_front());
         e2 = ref_mul(pr2[39:20], pr2[19:0], 2, 0);
         chk("c_k2", port_c2, e2[19:0]);
         chk("flag_k2", flag2, e2[20]);
      end
      if (in_valid2) begin
         qb.push_back({a2, b2});
         qb_acc.push_back(edges + 1);
      end

      @(posedge clk);
      edges++;
      #1;
      chk("cnt0", cnt0, m0[7:0]);
      chk("cnt1", cnt1, m0[7:0]);
      chk("cnt3", cnt3, m3[1:0]);
   endtask

   // Assert reset between edges and confirm outputs clear at once.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid0, 1'b0);
      chk("rst_port_c", port_c0, 12'h000);
      chk("rst_flag", flag0, 1'b0);
      chk("rst_cnt0", cnt0, 8'd0);
      chk("rst_cnt3", cnt3, 2'd0);
      chk("rst_in_ready", in_ready0, 1'b1);
      chk("rst_out_valid_k2", out_valid2, 1'b0);
      qa.delete();
      qa_acc.delete();
      qb.delete();
      qb_acc.delete();
      m0 = 0;
      m3 = 0;
      in_valid  = 1'b0;
      in_valid2 = 1'b0;
      clr_cnt   = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      bit          acc;
      int          sent;
      int          idx;
      logic [11:0] held_c;
      logic        held_f;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
      a = '0; b = '0; in_valid2 = 1'b0; a2 = '0; b2 = '0;
      @(posedge clk);
      #1;
      do_reset();

      // 1: fault-free product 0xB & 0x6 = 0x2.
      a = 12'hBBB; b = 12'h666; in_valid = 1'b1;
      cyc(acc);
      in_valid = 1'b0;
      cyc(acc);
      chk("t1_out_valid", out_valid0, 1'b1);
      chk("t1_port_c", port_c0, 12'h222);
      chk("t1_flag", flag0, 1'b0);
      cyc(acc);
      chk("t1_cnt", cnt0, 8'd0);

      // 2/3: replica 1 of bit 1 of A forced low.
      a = 12'hBBB & ~12'h020; b = 12'h666; in_valid = 1'b1;
      cyc(acc);
      in_valid = 1'b0;
      cyc(acc);
      chk("t2_port_c", port_c0, 12'h222);
      chk("t2_flag", flag0, 1'b1);
      chk("t3_detect_c", port_c1, 12'h000);
      chk("t3_detect_flag", flag1, 1'b1);
      cyc(acc);
      chk("t2_cnt", cnt0, 8'd1);
      a = 12'hFFF; b = 12'hFFF; in_valid = 1'b1;
      cyc(acc);
      in_valid = 1'b0;
      cyc(acc);
      chk("t3_clean_c", port_c1, 12'hFFF);
      chk("t3_clean_flag", flag1, 1'b0);
      cyc(acc);

      // 4: N=5, two then three replicas of bit 3 set on a zero operand.
      a2 = 20'h00088; b2 = 20'h00088; in_valid2 = 1'b1;
      cyc(acc);
      a2 = 20'h00888; b2 = 20'h00888;
      cyc(acc);
      in_valid2 = 1'b0;
      chk("t4_two_c", port_c2, 20'h00000);
      chk("t4_two_flag", flag2, 1'b1);
      cyc(acc);
      chk("t4_three_c", port_c2, 20'h88888);
      chk("t4_three_flag", flag2, 1'b1);
      cyc(acc);

      // 5: backpressure with four pairs, consumer stalled for three cycles.
      out_ready = 1'b0;
      sent = 0;
      a = 12'(rep(4'($urandom_range(0, 15)), 3));
      b = 12'(rep(4'($urandom_range(0, 15)), 3));
      for (int t = 0; t < 12 && sent < 4; t++) begin
         in_valid = 1'b1;
         if (t == 3) out_ready = 1'b1;
         cyc(acc);
         if (acc) begin
            sent++;
            a = 12'(rep(4'($urandom_range(0, 15)), 3));
            b = 12'(rep(4'($urandom_range(0, 15)), 3));
         end
         if (t == 1) begin
            chk("t5_in_ready_low", in_ready0, 1'b0);
            held_c = port_c0;
            held_f = flag0;
         end
         if (t == 2) begin
            chk("t5_hold_c", port_c0, held_c);
            chk("t5_hold_flag", flag0, held_f);
            chk("t5_hold_valid", out_valid0, 1'b1);
         end
      end
      in_valid = 1'b0;
      chk("t5_all_sent", sent, 4);
      repeat (4) cyc(acc);
      chk("t5_drained", qa.size(), 0);

      // Randomized traffic on both groups.
      for (int t = 0; t < 80; t++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         clr_cnt   = ($urandom_range(0, 15) == 0);
         a = 12'(rep(4'($urandom_range(0, 15)), 3));
         b = 12'(rep(4'($urandom_range(0, 15)), 3));
         if ($urandom_range(0, 1) == 0) begin
            idx = int'($urandom_range(0, 11));
            a[idx] = ~a[idx];
         end
         if ($urandom_range(0, 2) == 0) begin
            idx = int'($urandom_range(0, 11));
            b[idx] = ~b[idx];
         end
         in_valid2 = ($urandom_range(0, 1) != 0);
         a2 = rep(4'($urandom_range(0, 15)), 5);
         b2 = rep(4'($urandom_range(0, 15)), 5);
         for (int f = 0; f < int'($urandom_range(0, 3)); f++) begin
            idx = int'($urandom_range(0, 19));
            a2[idx] = ~a2[idx];
         end
         cyc(acc);
      end
      in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
      repeat (3) cyc(acc);

      // 6: saturation of a 2-bit counter, clear priority, reset mid-stream.
      clr_cnt = 1'b1;
      cyc(acc);
      clr_cnt = 1'b0;
      a = 12'hBBB & ~12'h020; b = 12'h666;
      in_valid = 1'b1;
      repeat (5) cyc(acc);
      in_valid = 1'b0;
      repeat (3) cyc(acc);
      chk("t6_sat", cnt3, 2'd3);
      chk("t6_cnt0_five", cnt0, 8'd5);
      in_valid = 1'b1;
      cyc(acc);
      cyc(acc);
      in_valid = 1'b0;
      clr_cnt  = 1'b1;
      cyc(acc);
      clr_cnt = 1'b0;
      chk("t6_clr_prio3", cnt3, 2'd0);
      chk("t6_clr_prio0", cnt0, 8'd0);
      cyc(acc);
      chk("t6_after_clr", cnt3, 2'd1);
      in_valid = 1'b1;
      cyc(acc);
      cyc(acc);
      do_reset();
      out_ready = 1'b1;
      repeat (3) cyc(acc);
      chk("t6_post_reset_cnt", cnt0, 8'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
